// File: rtl/iq_pair_fifo.sv
// Single-clock I/Q pair FIFO: one {Q,I} pair per write, read back as a whole
// pair or as I then Q. Status flags, sticky errors and a debug read port.
module iq_pair_fifo #(
  parameter int unsigned ADDR_WID = 5,
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned AF_LEVEL = 28
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WID-1:0]   WR_I,
  input  logic [DATA_WID-1:0]   WR_Q,
  input  logic                  RD_EN,
  input  logic                  MODE_SER,
  input  logic                  CLR_ERR,
  output logic [2*DATA_WID-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  RD_IS_Q,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic [ADDR_WID:0]     LEVEL,
  output logic                  OVF,
  output logic                  UDF,
  input  logic                  DEBUG_EN,
  input  logic [ADDR_WID-1:0]   ADDR_DEBUG,
  output logic [2*DATA_WID-1:0] DATA_DEBUG
);

  localparam int unsigned      DEPTH    = 1 << ADDR_WID;
  localparam logic [ADDR_WID:0] LVL_FULL = (ADDR_WID+1)'(DEPTH);
  localparam logic [ADDR_WID:0] LVL_AF   = (ADDR_WID+1)'(AF_LEVEL);

  logic [2*DATA_WID-1:0] r_mem [DEPTH];
  logic [ADDR_WID-1:0]   r_wptr;
  logic [ADDR_WID-1:0]   r_rptr;
  logic [ADDR_WID:0]     r_level;
  logic                  r_half;
  logic                  r_mode_ser;
  logic [2*DATA_WID-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_is_q;
  logic                  r_ovf;
  logic                  r_udf;
  logic [2*DATA_WID-1:0] r_data_debug;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_mode_ser;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_pop;
  logic [2*DATA_WID-1:0] w_head;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  // A pair half-read in serial mode must finish serially, so the live
  // MODE_SER input only takes effect between pairs.
  assign w_mode_ser = r_half ? r_mode_ser : MODE_SER;

  assign w_wr_acc = WR_EN && !w_full;
  assign w_rd_acc = RD_EN && !w_empty;
  assign w_pop    = w_rd_acc && (!w_mode_ser || r_half);
  assign w_head   = r_mem[r_rptr];

  // NOTE: storage has no reset; clearing the pointers and LEVEL is enough to
  // discard contents, and a reset-free array maps onto RAM primitives.
  always_ff @(posedge CLK) begin
    if (w_wr_acc && !RST) begin
      r_mem[r_wptr] <= {WR_Q, WR_I};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_half       <= 1'b0;
      r_mode_ser   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_is_q    <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_data_debug <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;

      if (w_rd_acc) begin
        if (!w_mode_ser) begin
          r_rd_data <= w_head;
          r_rd_is_q <= 1'b0;
        end else if (!r_half) begin
          r_rd_data <= {{DATA_WID{1'b0}}, w_head[DATA_WID-1:0]};
          r_rd_is_q <= 1'b0;
        end else begin
          r_rd_data <= {{DATA_WID{1'b0}}, w_head[2*DATA_WID-1:DATA_WID]};
          r_rd_is_q <= 1'b1;
        end
      end

      if (w_rd_acc && w_mode_ser) begin
        r_half <= !r_half;
      end
      if (!r_half) begin
        r_mode_ser <= MODE_SER;
      end

      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // Error set events take priority over a same-cycle clear.
      r_ovf <= (WR_EN && w_full)  || (r_ovf && !CLR_ERR);
      r_udf <= (RD_EN && w_empty) || (r_udf && !CLR_ERR);

      // NOTE: non-blocking write above means a same-address debug read
      // here sees the pre-write contents.
      if (DEBUG_EN) begin
        r_data_debug <= r_mem[ADDR_DEBUG];
      end
    end
  end

  assign RD_DATA    = r_rd_data;
  assign RD_VALID   = r_rd_valid;
  assign RD_IS_Q    = r_rd_is_q;
  assign FULL       = w_full;
  assign EMPTY      = w_empty;
  assign AFULL      = (r_level >= LVL_AF);
  assign LEVEL      = r_level;
  assign OVF        = r_ovf;
  assign UDF        = r_udf;
  assign DATA_DEBUG = r_data_debug;

endmodule

// File: tb/tb_iq_pair_fifo.sv
// Directed bench for iq_pair_fifo: queue-based reference model plus an
// expected-read scoreboard, checked every cycle one step after the edge.
module tb_iq_pair_fifo;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int AF    = 28;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [31:0] data;
    logic        is_q;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, mode_ser, clr_err, debug_en;
  logic [DW-1:0] wr_i, wr_q;
  logic [AW-1:0] addr_debug;
  logic [31:0]   rd_data, data_debug;
  logic          rd_valid, rd_is_q, full, empty, afull, ovf, udf;
  logic [AW:0]   level;

  iq_pair_fifo #(.ADDR_WID(AW), .DATA_WID(DW), .AF_LEVEL(AF)) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_I(wr_i), .WR_Q(wr_q),
    .RD_EN(rd_en), .MODE_SER(mode_ser), .CLR_ERR(clr_err),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_IS_Q(rd_is_q),
    .FULL(full), .EMPTY(empty), .AFULL(afull), .LEVEL(level),
    .OVF(ovf), .UDF(udf), .DEBUG_EN(debug_en), .ADDR_DEBUG(addr_debug),
    .DATA_DEBUG(data_debug)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_fifo[$];
  logic [31:0] m_mem [DEPTH];
  logic [AW-1:0] m_wptr;
  bit          m_half, m_mode, m_ovf, m_udf;
  logic [31:0] e_rd_data, e_dbg;
  logic        e_is_q;
  exp_t        exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pair(input int k);
    wr_i = 16'(k);
    wr_q = 16'h8000 | 16'(k);
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // clock the DUT and compare every output against the model.
  task automatic tick();
    bit full_m, empty_m, mode, old_half, pop, ev;
    logic [31:0] head;
    exp_t e;
    full_m   = (m_fifo.size() == DEPTH);
    empty_m  = (m_fifo.size() == 0);
    old_half = m_half;
    mode     = m_half ? m_mode : mode_ser;
    pop = 0;
    ev  = 0;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_wptr = '0; m_half = 0; m_mode = 0; m_ovf = 0; m_udf = 0;
      e_rd_data = '0; e_is_q = 1'b0; e_dbg = '0;
    end else begin
      if (rd_en && !empty_m) begin
        head = m_fifo[0];
        ev = 1;
        if (!mode) begin
          exp_q.push_back('{data: head, is_q: 1'b0});
          pop = 1;
        end else if (!old_half) begin
          exp_q.push_back('{data: {16'h0, head[15:0]}, is_q: 1'b0});
          m_half = 1;
        end else begin
          exp_q.push_back('{data: {16'h0, head[31:16]}, is_q: 1'b1});
          m_half = 0;
          pop = 1;
        end
      end
      if (!old_half) m_mode = mode_ser;
      if (debug_en) e_dbg = m_mem[addr_debug];
      if (pop) void'(m_fifo.pop_front());
      if (wr_en && !full_m) begin
        m_mem[m_wptr] = {wr_q, wr_i};
        m_wptr = m_wptr + 1'b1;
        m_fifo.push_back({wr_q, wr_i});
      end
      m_ovf = (wr_en && full_m)  || (m_ovf && !clr_err);
      m_udf = (rd_en && empty_m) || (m_udf && !clr_err);
    end

    @(posedge clk);
    #1;
    check("rd_valid", 32'(rd_valid), 32'(ev));
    if (rd_valid === 1'b1) begin
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_rd_data = e.data;
        e_is_q    = e.is_q;
      end
    end
    check("rd_data",    rd_data,           e_rd_data);
    check("rd_is_q",    32'(rd_is_q),      32'(e_is_q));
    check("level",      32'(level),        32'(m_fifo.size()));
    check("empty",      32'(empty),        32'(m_fifo.size() == 0));
    check("full",       32'(full),         32'(m_fifo.size() == DEPTH));
    check("afull",      32'(afull),        32'(m_fifo.size() >= AF));
    check("ovf",        32'(ovf),          32'(m_ovf));
    check("udf",        32'(udf),          32'(m_udf));
    check("data_debug", data_debug,        e_dbg);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; mode_ser = 1'b0; clr_err = 1'b0;
    debug_en = 1'b0; addr_debug = '0; wr_i = '0; wr_q = '0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Fill to full; the 33rd write is dropped and raises OVF
    wr_en = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      set_pair(k);
      tick();
    end
    wr_en = 1'b0;

    // Pair-mode drain, then one read on empty for UDF
    rd_en = 1'b1;
    for (int k = 0; k < 33; k++) tick();
    rd_en = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Serial mode: 3 pairs out as 6 half-reads
    mode_ser = 1'b1;
    wr_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_pair(k);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    rd_en = 1'b0;
    mode_ser = 1'b0;
    tick();

    // Streaming write+read across pointer wrap with LEVEL held at 4
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_pair(16'h0100 + k);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 4; k < 104; k++) begin
      set_pair(16'h0100 + k);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rd_en = 1'b0;
    tick();

    // Mode change deferred until the Q half of a pair is read
    wr_en = 1'b1;
    set_pair(16'h0201); tick();
    set_pair(16'h0202); tick();
    wr_en = 1'b0;
    mode_ser = 1'b1;
    rd_en = 1'b1;
    tick();
    mode_ser = 1'b0;
    tick();
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    clr_err = 1'b0;
    tick();

    // Debug port: known entry, hold, same-address write returns old data
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      set_pair(k);
      tick();
    end
    wr_en = 1'b0;
    debug_en = 1'b1;
    addr_debug = 5'd3;
    tick();
    debug_en = 1'b0;
    tick();
    wr_en = 1'b1;
    set_pair(6);
    debug_en = 1'b1;
    addr_debug = 5'd5;
    tick();
    wr_en = 1'b0;
    tick();
    debug_en = 1'b0;

    // Reset in the middle of a serial pair
    mode_ser = 1'b1;
    rd_en = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_en = 1'b0;
    mode_ser = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
